// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, empty/full flags and occupancy count.
// Simultaneous read and write is accepted even when full, since the read frees the slot being written.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   fifo_cnt
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  assign empty = (fifo_cnt == '0);
  assign full  = (fifo_cnt == FULL_CNT);

  always_comb begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_en = wr && (!full || rd);
    rd_en = rd && !empty;
  end

  // Storage is intentionally not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      data_out <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed, table-driven bench for sync_fifo plus hand-written reset corner sequences.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       wr;
  logic       rd;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic [3:0] fifo_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic [3:0] exp_cnt;
    logic       exp_empty;
    logic       exp_full;
  } vec_t;

  vec_t vecs[$];

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input int dout, input int cnt, input int emp, input int ful);
    check({name, ".data_out"}, int'(data_out), dout);
    check({name, ".fifo_cnt"}, int'(fifo_cnt), cnt);
    check({name, ".empty"}, int'(empty), emp);
    check({name, ".full"}, int'(full), ful);
  endtask

  function automatic void add(input logic w, input logic r, input int din, input int dout, input int cnt);
    vec_t v;
    v.wr        = w;
    v.rd        = r;
    v.din       = 8'(din);
    v.exp_dout  = 8'(dout);
    v.exp_cnt   = 4'(cnt);
    v.exp_empty = (cnt == 0);
    v.exp_full  = (cnt == 8);
    vecs.push_back(v);
  endfunction

  task automatic cycle(input logic w, input logic r, input logic [7:0] din);
    wr      = w;
    rd      = r;
    data_in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Basic push / simultaneous push+pop / pop
    add(1, 0, 1, 0, 1);
    add(1, 1, 2, 1, 1);
    add(0, 1, 0, 2, 0);
    // Fill from empty; 90..130 dropped while full
    for (int i = 1; i <= 13; i++) add(1, 0, i * 10, 2, (i < 8) ? i : 8);
    // Drain, then one extra pop on empty
    for (int i = 1; i <= 8; i++) add(0, 1, 0, i * 10, 8 - i);
    add(0, 1, 0, 80, 0);
    // Refill, pop 3, push 3 across the pointer wrap, drain
    for (int i = 1; i <= 8; i++) add(1, 0, i * 10, 80, i);
    for (int i = 1; i <= 3; i++) add(0, 1, 0, i * 10, 8 - i);
    add(1, 0, 140, 30, 6);
    add(1, 0, 150, 30, 7);
    add(1, 0, 160, 30, 8);
    for (int i = 4; i <= 8; i++) add(0, 1, 0, i * 10, 8 - (i - 3));
    add(0, 1, 0, 140, 2);
    add(0, 1, 0, 150, 1);
    add(0, 1, 0, 160, 0);
    // rd+wr while empty: write only
    add(1, 1, 7, 160, 1);
    add(0, 1, 0, 7, 0);
    // rd+wr while full: oldest popped, new word stored, count stays 8
    for (int i = 1; i <= 8; i++) add(1, 0, i, 7, i);
    add(1, 1, 99, 1, 8);
    for (int i = 2; i <= 8; i++) add(0, 1, 0, i, 8 - (i - 1));
    add(0, 1, 0, 99, 0);

    wr = 1'b0; rd = 1'b0; data_in = '0;
    rst = 1'b0;
    #2;
    check_all("reset_no_clk", 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      cycle(vecs[i].wr, vecs[i].rd, vecs[i].din);
      check_all($sformatf("vec%0d", i), int'(vecs[i].exp_dout), int'(vecs[i].exp_cnt),
                int'(vecs[i].exp_empty), int'(vecs[i].exp_full));
    end

    // Asynchronous reset mid-fill takes effect without a clock edge
    cycle(1, 0, 11);
    cycle(1, 0, 22);
    cycle(1, 0, 33);
    check_all("prefill", 99, 3, 0, 0);
    wr = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    cycle(1, 0, 44);
    check_all("post_reset_push", 0, 1, 0, 0);
    cycle(0, 1, 0);
    check_all("post_reset_pop", 44, 0, 1, 0);
    cycle(0, 0, 0);
    check_all("idle_hold", 44, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
